cam_pipe_sequencer: RTL

Power-up and streaming sequencer for the camera pipeline; replaces the fixed cam_en/i2c_areset_n timing in the clock/reset generator.
Sequences camera power enable, I2C register load and CSI_RX/ISP reset release, then watches csi_in_frame activity.
On a lost stream it power-cycles the camera and retries, up to a bounded count. Sits in top in the clk_100 domain, next to clkrst_gen and i2c_top.

---
 rtl/cam_pipe_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cam_pipe_sequencer.sv
// Camera power-up / streaming sequencer for the clk_100 domain.
// Power-cycles the sensor, loads it over I2C, releases CSI reset, watches frames.
module cam_pipe_sequencer #(
  parameter int unsigned PWR_CYC       = 2_000_000,
  parameter int unsigned SETTLE_CYC    = 1_000_000,
  parameter int unsigned I2C_TMO_CYC   = 10_000_000,
  parameter int unsigned FRAME_TMO_CYC = 20_000_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TMR_W         = 32,
  parameter int unsigned FCNT_W        = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              enable,
  input  logic              i2c_done,
  input  logic              i2c_err,
  input  logic              csi_in_frame,
  output logic              cam_en,
  output logic              i2c_start,
  output logic              csi_reset,
  output logic              streaming,
  output logic              fault,
  output logic [2:0]        state_o,
  output logic [1:0]        retry_cnt,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PWR_OFF     = 3'd1,
    S_PWR_ON      = 3'd2,
    S_I2C_RUN     = 3'd3,
    S_STREAM_WAIT = 3'd4,
    S_STREAM      = 3'd5,
    S_RETRY       = 3'd6,
    S_FAULT       = 3'd7
  } state_t;

  localparam logic [TMR_W-1:0] T_PWR = TMR_W'(PWR_CYC - 1);
  localparam logic [TMR_W-1:0] T_SET = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] T_I2C = TMR_W'(I2C_TMO_CYC - 1);
  localparam logic [TMR_W-1:0] T_FRM = TMR_W'(FRAME_TMO_CYC - 1);
  localparam logic [1:0]       R_MAX = 2'(MAX_RETRY);

  state_t             state, state_n;
  logic [TMR_W-1:0]   tmr, tmr_n;
  logic [1:0]         retry_n;
  logic [FCNT_W-1:0]  fcnt_n;
  logic               start_n;
  logic               tmr_clr;
  logic               sync1, sync2, sync2_d;
  logic               frame_edge;

  // csi_in_frame comes from the byte-clock domain
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= csi_in_frame;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign frame_edge = sync2 & ~sync2_d;

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    start_n = 1'b0;
    tmr_clr = 1'b0;
    if (state != S_IDLE && !enable) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable) state_n = S_PWR_OFF;
        end
        S_PWR_OFF: begin
          if (tmr == T_PWR) state_n = S_PWR_ON;
        end
        S_PWR_ON: begin
          if (tmr == T_SET) begin
            state_n = S_I2C_RUN;
            start_n = 1'b1;
          end
        end
        S_I2C_RUN: begin
          if (i2c_err || tmr == T_I2C) state_n = S_RETRY;
          else if (i2c_done)           state_n = S_STREAM_WAIT;
        end
        S_STREAM_WAIT: begin
          if (frame_edge)        state_n = S_STREAM;
          else if (tmr == T_FRM) state_n = S_RETRY;
        end
        S_STREAM: begin
          if (frame_edge)        tmr_clr = 1'b1;
          else if (tmr == T_FRM) state_n = S_RETRY;
        end
        S_RETRY: begin
          if (retry_cnt == R_MAX) begin
            state_n = S_FAULT;
          end else begin
            state_n = S_PWR_OFF;
            retry_n = retry_cnt + 2'd1;
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
      endcase
    end
    // A good stream or an explicit stop forgives earlier failures
    if (state_n != state &&
        (state_n == S_IDLE || state_n == S_STREAM))
      retry_n = 2'd0;
  end

  always_comb begin
    tmr_n = tmr;
    if (state_n != state || tmr_clr)
      tmr_n = '0;
    else if (tmr != '1)
      tmr_n = tmr + TMR_W'(1);
  end

  always_comb begin
    fcnt_n = frame_cnt;
    if (state_n == S_STREAM_WAIT && state != S_STREAM_WAIT)
      fcnt_n = '0;
    else if (frame_edge &&
             (state == S_STREAM_WAIT || state == S_STREAM))
      fcnt_n = frame_cnt + FCNT_W'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      retry_cnt <= 2'd0;
      frame_cnt <= '0;
      cam_en    <= 1'b0;
      i2c_start <= 1'b0;
      csi_reset <= 1'b1;
      streaming <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      retry_cnt <= retry_n;
      frame_cnt <= fcnt_n;
      i2c_start <= start_n;
      cam_en    <= state_n inside {S_PWR_ON, S_I2C_RUN,
                                   S_STREAM_WAIT, S_STREAM};
      csi_reset <= !(state_n inside {S_STREAM_WAIT, S_STREAM});
      streaming <= (state_n == S_STREAM);
      fault     <= (state_n == S_FAULT);
    end
  end

  assign state_o = state;

endmodule
